// File: rtl/reg_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bus_arbiter_pkg
//  Brief    : Shared types and constants for the register bus arbiter:
//             FSM state encodings, master IDs and default read latency.
//  Revision : 1.0  initial release
// ============================================================================
package reg_bus_arbiter_pkg;

    // Arbiter FSM states, explicitly encoded
    typedef enum logic [2:0] {
        c_ST_IDLE  = 3'd0,
        c_ST_SETUP = 3'd1,
        c_ST_XFER  = 3'd2,
        c_ST_DRAIN = 3'd3,
        c_ST_DONE  = 3'd4
    } arb_state_t;

    // Master identifiers
    localparam logic c_M0 = 1'b0;   // USB front-end
    localparam logic c_M1 = 1'b1;   // internal configuration sequencer

    // Read latency of a registered-read slave
    localparam int c_DEFAULT_READ_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/reg_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module   : reg_arb_rr2
//  Brief    : Two-way round-robin grant. Grants only while enabled; when both
//             masters request, the one not granted last wins. After reset the
//             last-grant register points at M1 so that M0 wins first.
//  Revision : 1.0  initial release
// ============================================================================
module reg_arb_rr2
    import reg_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    logic       r_last;     // ID of the most recently granted master
    logic [1:0] w_grant;

    // One-hot grant decision from the current requests and last winner
    always_comb begin
        w_grant = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = (r_last == c_M0) ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // Remember who won so the other master is favoured next time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= c_M1;
        end else if (w_grant != 2'b00) begin
            r_last <= w_grant[1];
        end
    end

    assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bus_arbiter
//  Brief    : Burst-granular round-robin arbiter sharing the byte-serial
//             register bus between m0 (USB front-end) and m1 (config
//             sequencer). Drives address/bytecnt/strobes toward the trace
//             register block and returns read bytes to the owning master.
//             Optional macro REG_ARB_TIMEOUT_EN adds a write-stall watchdog
//             that aborts a stalled write burst with done+err.
//  Revision : 1.0  initial release
// ============================================================================
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pREAD_LATENCY = c_DEFAULT_READ_LATENCY,
    parameter int pTIMEOUT      = 255
)(
    input  logic                     usb_clk,
    input  logic                     reset_i,
    // master 0
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [7:0]               m0_addr,
    input  logic [pBYTECNT_SIZE-1:0] m0_len,
    input  logic [7:0]               m0_wdata,
    input  logic                     m0_wvalid,
    output logic                     m0_wready,
    output logic [7:0]               m0_rdata,
    output logic                     m0_rvalid,
    output logic                     m0_done,
    output logic                     m0_err,
    // master 1
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [7:0]               m1_addr,
    input  logic [pBYTECNT_SIZE-1:0] m1_len,
    input  logic [7:0]               m1_wdata,
    input  logic                     m1_wvalid,
    output logic                     m1_wready,
    output logic [7:0]               m1_rdata,
    output logic                     m1_rvalid,
    output logic                     m1_done,
    output logic                     m1_err,
    // slave register bus
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               write_data,
    output logic                     reg_write,
    output logic                     reg_read,
    output logic                     reg_addrvalid,
    input  logic [7:0]               read_data,
    output logic                     busy
);

    localparam logic [pBYTECNT_SIZE-1:0] c_BC_ONE = pBYTECNT_SIZE'(1);
    localparam logic [1:0] c_DRAIN_LAST =
        (pREAD_LATENCY > 0) ? 2'(pREAD_LATENCY - 1) : 2'd0;

    arb_state_t                 r_state;
    logic                       r_owner;
    logic                       r_we;
    logic [7:0]                 r_addr;
    logic [pBYTECNT_SIZE-1:0]   r_len;
    logic [pBYTECNT_SIZE-1:0]   r_bytecnt;
    logic                       r_addrvalid;
    logic [1:0]                 r_drain_cnt;

    logic [1:0]                 w_grant;
    logic                       w_owner_wvalid;
    logic [7:0]                 w_owner_wdata;
    logic                       w_wr_accept;
    logic                       w_rd_strobe;
    logic                       w_last;
    logic                       w_ret_valid;
    logic                       w_done_err;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int c_STALL_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT + 1) : 1;
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(pTIMEOUT - 1);
    logic [c_STALL_W-1:0]       r_stall_cnt;
    logic                       r_err;
`else
    // The watchdog limit has no effect when the watchdog is not built
    localparam logic c_ERR_TIE = 1'b0 && (pTIMEOUT > 0);
`endif

    reg_arb_rr2 u_rr (
        .clk     (usb_clk),
        .rst     (reset_i),
        .i_req   ({m1_req, m0_req}),
        .i_en    (r_state == c_ST_IDLE),
        .o_grant (w_grant)
    );

    assign w_owner_wvalid = r_owner ? m1_wvalid : m0_wvalid;
    assign w_owner_wdata  = r_owner ? m1_wdata  : m0_wdata;
    assign w_wr_accept    = (r_state == c_ST_XFER) && r_we && w_owner_wvalid;
    assign w_rd_strobe    = (r_state == c_ST_XFER) && !r_we;
    assign w_last         = (r_bytecnt == (r_len - c_BC_ONE));

    // Read-return valid: a reg_read delayed by the slave latency
    generate
        if (pREAD_LATENCY == 0) begin : g_lat0
            assign w_ret_valid = w_rd_strobe;
        end else begin : g_latn
            logic [pREAD_LATENCY-1:0] r_rd_pipe;

            // Shift strobes toward the return port; reset flushes in-flight reads
            always_ff @(posedge usb_clk or posedge reset_i) begin
                if (reset_i) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe[0] <= w_rd_strobe;
                    for (int i = 1; i < pREAD_LATENCY; i++) begin
                        r_rd_pipe[i] <= r_rd_pipe[i-1];
                    end
                end
            end

            assign w_ret_valid = r_rd_pipe[pREAD_LATENCY-1];
        end
    endgenerate

    // Burst sequencer: grant latch, byte counting and state transitions
    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= c_ST_IDLE;
            r_owner     <= c_M0;
            r_we        <= 1'b0;
            r_addr      <= 8'h00;
            r_len       <= '0;
            r_bytecnt   <= '0;
            r_addrvalid <= 1'b0;
            r_drain_cnt <= 2'd0;
`ifdef REG_ARB_TIMEOUT_EN
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_owner     <= w_grant[1];
                        r_we        <= w_grant[1] ? m1_we   : m0_we;
                        r_addr      <= w_grant[1] ? m1_addr : m0_addr;
                        r_len       <= w_grant[1] ? m1_len  : m0_len;
                        r_bytecnt   <= '0;
                        r_addrvalid <= 1'b1;
                        r_state     <= c_ST_SETUP;
`ifdef REG_ARB_TIMEOUT_EN
                        r_stall_cnt <= '0;
                        r_err       <= 1'b0;
`endif
                    end
                end

                c_ST_SETUP: begin
                    if (r_len != '0) begin
                        r_state <= c_ST_XFER;
                    end else begin
                        r_addrvalid <= 1'b0;
                        r_state     <= c_ST_DONE;
                    end
                end

                c_ST_XFER: begin
                    if (r_we) begin
                        if (w_wr_accept) begin
`ifdef REG_ARB_TIMEOUT_EN
                            r_stall_cnt <= '0;
`endif
                            if (w_last) begin
                                r_bytecnt   <= '0;
                                r_addrvalid <= 1'b0;
                                r_state     <= c_ST_DONE;
                            end else begin
                                r_bytecnt <= r_bytecnt + c_BC_ONE;
                            end
                        end
`ifdef REG_ARB_TIMEOUT_EN
                        else if (r_stall_cnt == c_STALL_LAST) begin
                            // Master stopped feeding bytes: abandon the burst
                            r_err       <= 1'b1;
                            r_bytecnt   <= '0;
                            r_addrvalid <= 1'b0;
                            r_state     <= c_ST_DONE;
                        end else begin
                            r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
                        end
`endif
                    end else begin
                        if (w_last) begin
                            if (pREAD_LATENCY == 0) begin
                                r_bytecnt   <= '0;
                                r_addrvalid <= 1'b0;
                                r_state     <= c_ST_DONE;
                            end else begin
                                r_drain_cnt <= 2'd0;
                                r_state     <= c_ST_DRAIN;
                            end
                        end else begin
                            r_bytecnt <= r_bytecnt + c_BC_ONE;
                        end
                    end
                end

                c_ST_DRAIN: begin
                    // Address stays valid until the last read byte is returned
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_bytecnt   <= '0;
                        r_addrvalid <= 1'b0;
                        r_state     <= c_ST_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    assign w_done_err = r_err;
`else
    assign w_done_err = c_ERR_TIE;
`endif

    // Slave side
    assign reg_address   = r_addr;
    assign reg_bytecnt   = r_bytecnt;
    assign reg_addrvalid = r_addrvalid;
    assign reg_write     = w_wr_accept;
    assign reg_read      = w_rd_strobe;
    assign write_data    = w_wr_accept ? w_owner_wdata : 8'h00;
    assign busy          = (r_state != c_ST_IDLE);

    // Master side: only the owner ever sees activity
    assign m0_wready = w_wr_accept && (r_owner == c_M0);
    assign m1_wready = w_wr_accept && (r_owner == c_M1);
    assign m0_rvalid = w_ret_valid && (r_owner == c_M0);
    assign m1_rvalid = w_ret_valid && (r_owner == c_M1);
    assign m0_rdata  = m0_rvalid ? read_data : 8'h00;
    assign m1_rdata  = m1_rvalid ? read_data : 8'h00;
    assign m0_done   = (r_state == c_ST_DONE) && (r_owner == c_M0);
    assign m1_done   = (r_state == c_ST_DONE) && (r_owner == c_M1);
    assign m0_err    = m0_done && w_done_err;
    assign m1_err    = m1_done && w_done_err;

endmodule
`default_nettype wire

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
Shares the byte-serial register bus that feeds the trace register block between two masters: m0 is the USB front-end and m1 is an internal configuration sequencer. The arbiter grants one whole burst at a time, round-robin. For each granted burst it drives address, addrvalid, bytecnt and read/write strobes on the slave bus, and returns read bytes to the owning master after a fixed latency. It sits between the masters and the trace register block, in the usb_clk domain.

Parameters:
pBYTECNT_SIZE, 7, width of slave reg_bytecnt and of master burst length.
pREAD_LATENCY, 1, cycles from slave reg_read to valid slave read_data; legal range 0..3 (1 matches registered-read slaves).
pTIMEOUT, 255, write-stall watchdog limit in cycles; used only with REG_ARB_TIMEOUT_EN.

Ports:
usb_clk  in  1  clock
reset_i  in  1  asynchronous reset, active-high
mN_req  in  1  burst request; hold until mN_done (N = 0, 1 for every mN_ port)
mN_we  in  1  1 = write burst, 0 = read burst; stable while mN_req is high
mN_addr  in  8  register address; stable while mN_req is high
mN_len  in  pBYTECNT_SIZE  burst byte count; 0 = no-op
mN_wdata  in  8  write byte
mN_wvalid  in  1  mN_wdata is valid
mN_wready  out  1  write byte consumed this cycle
mN_rdata  out  8  read byte
mN_rvalid  out  1  mN_rdata is valid; the master must accept it, no backpressure
mN_done  out  1  one-cycle pulse at burst end
mN_err  out  1  one-cycle pulse with mN_done on timeout abort (macro only; otherwise tied 0)
reg_address  out  8  slave address
reg_bytecnt  out  pBYTECNT_SIZE  slave byte index
write_data  out  8  slave write byte
reg_write  out  1  slave write strobe
reg_read  out  1  slave read strobe
reg_addrvalid  out  1  slave address valid
read_data  in  8  slave read byte
busy  out  1  a burst is in progress (state is not IDLE)

Behaviour:
- Reset is asynchronous. All outputs go to 0, state goes to IDLE, the round-robin pointer is set to favour m0, and the read pipeline is flushed. A burst cut by reset is dropped silently; masters must re-request.
- FSM states are IDLE, SETUP, XFER, DRAIN, DONE.
- IDLE: with exactly one request pending, grant that master. With both pending, grant the master that was not granted last; after reset, grant m0. The grant and the master's addr/we/len are latched, then go to SETUP. No grant is ever issued while a burst is active.
- SETUP (1 cycle): reg_addrvalid=1, reg_address=latched addr, reg_bytecnt=0, no strobes. Go to XFER if len>0, else go to DONE.
- XFER, write burst: when wvalid is high, drive reg_write=1, write_data=wdata and wready=1 in the same cycle. reg_bytecnt advances by 1 after each accepted byte. When wvalid is low, reg_write=0 and bytecnt holds. After byte len-1 is accepted, go to DONE.
- XFER, read burst: reg_read=1 every cycle with bytecnt 0..len-1, no stalls, then go to DRAIN.
- Read return: read_data is captured pREAD_LATENCY cycles after each reg_read and presented on the owner's rdata with rvalid=1, one pulse per byte, in order. With latency 0, rvalid is asserted in the same cycle as reg_read.
- DRAIN: wait until the last rvalid has been issued, then go to DONE. With latency 0, DRAIN lasts 0 cycles.
- DONE (1 cycle): owner's done=1, reg_addrvalid=0, bytecnt reset to 0, then go to IDLE. A master still holding req after done may be re-granted no earlier than the cycle after DONE, subject to round-robin.
- reg_addrvalid stays high from SETUP through the end of DRAIN.
- Outputs to the non-owning master stay 0 throughout.
- len at maximum (2^pBYTECNT_SIZE-1): bytecnt reaches len-1 and never wraps.
- Back-to-back throughput: a burst of L bytes with no stalls takes 1 (IDLE) + 1 (SETUP) + L + pREAD_LATENCY (read only) + 1 (DONE) cycles.

Optional Feature:
Macro REG_ARB_TIMEOUT_EN.
- With it: a stall counter counts consecutive write-burst cycles with wvalid low and clears on any accepted byte. When the count reaches pTIMEOUT, the burst is aborted: go straight to DONE and pulse both done and err. Bytes already written stay written.
- Without it: no counter exists, err is tied to 0, and a stalled write waits indefinitely.

Decomposition:
- Shared defines include: FSM state encodings, master IDs (M0=0, M1=1), and the default latency constant.
- One sub-module, reg_arb_rr2: a 2-way round-robin grant with last-grant register, fed by req, enable and reset, outputting a one-hot grant.

Test Plan:
- m0 write, addr 0x10, len 8, wdata 0x01..0x08 with wvalid always high -> reg_write pulses on 8 consecutive cycles with bytecnt 0..7 and matching data; m0_done 10 cycles after grant.
- m1 read, addr 0x00, len 8, latency 1, slave returning "ArmTrace" bytes -> m1_rvalid asserted 8 times with bytes 0x41,0x72,0x6d,0x54,0x72,0x61,0x63,0x65; DRAIN lasts 1 cycle.
- m0 and m1 request in the same cycle after reset, each holding req for 3 bursts -> grant order m0, m1, m0, m1, m0, m1.
- Write len 4 with wvalid low on the byte-2 cycle for 5 cycles -> bytecnt holds at 2, no reg_write during the stall, data order intact. With REG_ARB_TIMEOUT_EN and pTIMEOUT=4 -> abort, done+err pulse, no bytes 2..3 written.
- reset_i asserted during XFER of a read, len 8 at byte 3 -> all outputs 0 immediately, no further rvalid; after release, a fresh request is granted to m0.
- len 0 request -> SETUP then DONE, done pulses, no reg_read or reg_write.
